// File: rtl/norm2_host_if.sv
// Bundle of the sample stream, result stream, status and kernel control port
// between norm2_host (master) and its environment (slave).
interface norm2_host_if #(
  parameter int AW = 10,
  parameter int DW = 27
);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [63:0]   m_data;
  logic                 busy;
  logic                 err;
  logic                 k_r_enable;
  logic [AW-1:0]        k_init_i;
  logic [63:0]          k_init_acc;
  logic                 k_controlArr;
  logic                 k_arr_we;
  logic [AW-1:0]        k_arr_addr;
  logic signed [DW-1:0] k_arr_wdata;
  logic signed [DW-1:0] k_arr_rdata;
  logic                 k_w_enable;
  logic signed [63:0]   k_result;

  modport master (
    input  s_valid, s_data, m_ready, k_arr_rdata, k_w_enable, k_result,
    output s_ready, m_valid, m_data, busy, err, k_r_enable, k_init_i,
           k_init_acc, k_controlArr, k_arr_we, k_arr_addr, k_arr_wdata
  );

  modport slave (
    output s_valid, s_data, m_ready, k_arr_rdata, k_w_enable, k_result,
    input  s_ready, m_valid, m_data, busy, err, k_r_enable, k_init_i,
           k_init_acc, k_controlArr, k_arr_we, k_arr_addr, k_arr_wdata
  );
endinterface

// File: rtl/norm2_host.sv
// Host-side driver for the sum-of-squares kernel: loads a job of samples into
// the kernel array, optionally checks a readback checksum, runs the kernel.
//
// state  | meaning
// IDLE   | waiting for the first sample of a job
// LOAD   | writing samples to the array; drain_q = final write still in flight
// VERIFY | reading the array back, folding the data into ck_r
// START  | array released to the kernel, one-cycle start pulse
// WAIT   | waiting for kernel done or timeout
// OUT    | holding the result until it is accepted
module norm2_host #(
  parameter int          N       = 1000,
  parameter int          AW      = 10,
  parameter int          DW      = 27,
  parameter bit          VERIFY  = 1'b1,
  parameter logic [31:0] TIMEOUT = 32'd20000
) (
  input logic          clk,
  input logic          rst_n,
  norm2_host_if.master bus
);

  localparam int            RW       = AW + 1;
  localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(N - 1);
  localparam logic [RW-1:0] RD_END   = RW'(N);
  localparam logic [31:0]   TMR_LAST = TIMEOUT - 32'd1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_START, S_WAIT, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [RW-1:0]        vcnt_q, vcnt_d;
  logic                 drain_q, drain_d;
  logic [DW-1:0]        ck_w_q, ck_w_d;
  logic [DW-1:0]        ck_r_q, ck_r_d;
  logic [31:0]          tmr_q, tmr_d;
  logic                 s_ready_q, s_ready_d;
  logic                 m_valid_q, m_valid_d;
  logic signed [63:0]   m_data_q, m_data_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 r_en_q, r_en_d;
  logic                 ctrl_q, ctrl_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic signed [DW-1:0] wdata_q, wdata_d;
  logic                 accept;

  assign accept = bus.s_valid && s_ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      vcnt_q    <= '0;
      drain_q   <= 1'b0;
      ck_w_q    <= '0;
      ck_r_q    <= '0;
      tmr_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      r_en_q    <= 1'b0;
      ctrl_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vcnt_q    <= vcnt_d;
      drain_q   <= drain_d;
      ck_w_q    <= ck_w_d;
      ck_r_q    <= ck_r_d;
      tmr_q     <= tmr_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      r_en_q    <= r_en_d;
      ctrl_q    <= ctrl_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vcnt_d    = vcnt_q;
    drain_d   = drain_q;
    ck_w_d    = ck_w_q;
    ck_r_d    = ck_r_q;
    tmr_d     = tmr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    err_d     = err_q;
    r_en_d    = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        // The last write lands one cycle after its handshake, so the array
        // port is only reused (or released) after that drain cycle.
        if (drain_q) begin
          drain_d = 1'b0;
          addr_d  = '0;
          vcnt_d  = '0;
          ck_r_d  = '0;
          if (VERIFY) begin
            state_d = S_VERIFY;
          end else begin
            state_d = S_START;
            r_en_d  = 1'b1;
          end
        end else if (accept) begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = bus.s_data;
          state_d = S_LOAD;
          if (state_q == S_IDLE) begin
            ck_w_d = bus.s_data;
            err_d  = 1'b0;
          end else begin
            ck_w_d = ck_w_q ^ bus.s_data;
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            drain_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_VERIFY: begin
        // Read data trails the address by one cycle: cycle 0 has nothing to fold.
        if (vcnt_q != '0) ck_r_d = ck_r_q ^ bus.k_arr_rdata;
        if (vcnt_q == RD_END) begin
          if ((ck_r_q ^ bus.k_arr_rdata) != ck_w_q) err_d = 1'b1;
          state_d = S_START;
          r_en_d  = 1'b1;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
          if (vcnt_q < RD_LAST) addr_d = addr_q + 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        tmr_d   = '0;
      end
      S_WAIT: begin
        // k_w_enable still shows the previous job's done in the first cycle.
        if (tmr_q != '0 && bus.k_w_enable) begin
          m_data_d  = bus.k_result;
          m_valid_d = 1'b1;
          state_d   = S_OUT;
        end else if (tmr_q >= TMR_LAST) begin
          err_d     = 1'b1;
          m_data_d  = '0;
          m_valid_d = 1'b1;
          state_d   = S_OUT;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_OUT: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD && !drain_d);
    ctrl_d    = !(state_d == S_START || state_d == S_WAIT || state_d == S_OUT);
    busy_d    = (state_d != S_IDLE);
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.m_valid      = m_valid_q;
  assign bus.m_data       = m_data_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
  assign bus.k_r_enable   = r_en_q;
  assign bus.k_init_i     = '0;
  assign bus.k_init_acc   = '0;
  assign bus.k_controlArr = ctrl_q;
  assign bus.k_arr_we     = we_q;
  assign bus.k_arr_addr   = addr_q;
  assign bus.k_arr_wdata  = wdata_q;

endmodule

// File: tb/tb_norm2_host.sv
// Bench for norm2_host: behavioural kernel stand-in plus sum-of-squares
// reference computed directly from the samples sent.
module tb_norm2_host;
  localparam int N  = 1000;
  localparam int AW = 10;
  localparam int DW = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  norm2_host_if #(.AW(AW), .DW(DW)) bus ();

  norm2_host #(.N(N), .AW(AW), .DW(DW), .VERIFY(1'b1), .TIMEOUT(32'd100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic signed [DW-1:0] smp [N];

  // kernel stand-in: 1-cycle read array, done flag cleared one edge after start
  logic signed [DW-1:0] karr [N];
  logic signed [DW-1:0] krd = '0;
  logic signed [63:0]   kres = '0;
  logic kw = 1'b0, krq = 1'b0, krun = 1'b0;
  int   kcnt = 0;
  bit   khang = 1'b0, kcorrupt = 1'b0;
  int   klat = 10;

  assign bus.k_arr_rdata = krd;
  assign bus.k_w_enable  = kw;
  assign bus.k_result    = kres;

  function automatic longint ksum();
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(karr[i]) * longint'(karr[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    krq <= bus.k_r_enable;
    if (int'(bus.k_arr_addr) < N) begin
      if (bus.k_controlArr && bus.k_arr_we) karr[bus.k_arr_addr] <= bus.k_arr_wdata;
      krd <= (kcorrupt && bus.k_arr_addr == 10'd17) ? (karr[bus.k_arr_addr] ^ 27'sd1)
                                                      : karr[bus.k_arr_addr];
    end
    if (krq) begin
      kw   <= 1'b0;
      kcnt <= klat;
      krun <= 1'b1;
    end else if (krun) begin
      if (kcnt == 0) begin
        krun <= 1'b0;
        kres <= ksum();
        kw   <= !khang;
      end else begin
        kcnt <= kcnt - 1;
      end
    end
  end

  // monitors
  int cyc = 0, acc_cnt = 0, beat_cnt = 0, ren_cnt = 0, own_bad = 0, sready_bad = 0, ren_cyc = 0;
  logic err_at_start = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.s_valid && bus.s_ready) acc_cnt <= acc_cnt + 1;
      if (bus.m_valid && bus.m_ready) beat_cnt <= beat_cnt + 1;
      if (bus.k_r_enable) begin
        ren_cnt      <= ren_cnt + 1;
        ren_cyc      <= cyc;
        err_at_start <= bus.err;
        if (bus.k_controlArr) own_bad <= own_bad + 1;
      end
      if (!bus.k_controlArr && bus.s_ready) sready_bad <= sready_bad + 1;
    end
  end

  function automatic longint exp_sum();
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(smp[i]) * longint'(smp[i]);
    return s;
  endfunction

  task automatic drive_samples(input int first, input int last, input int gap_pct, output bit ok);
    int i = first;
    int guard = 0;
    while (i < last && guard < 8000) begin
      @(negedge clk);
      guard++;
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.s_valid = 1'b0;
        bus.s_data  = DW'($urandom);
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = smp[i];
        if (bus.s_ready) i++;
      end
    end
    ok = (i == last);
  endtask

  task automatic wait_mvalid(input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (bus.m_valid) got = 1'b1;
    end
  endtask

  task automatic run_job(input int gap_pct, input int hold, input bit pre_ready, input bit keep_valid,
                         output bit sent_ok, output bit got, output logic signed [63:0] data,
                         output logic errv, output bit stable, output int mv_cyc);
    bus.m_ready = pre_ready;
    drive_samples(0, N, gap_pct, sent_ok);
    @(negedge clk);
    bus.s_valid = keep_valid;
    wait_mvalid(3000, got);
    data   = bus.m_data;
    errv   = bus.err;
    mv_cyc = cyc;
    stable = 1'b1;
    if (got && !pre_ready) begin
      repeat (hold) begin
        @(negedge clk);
        if (bus.m_valid !== 1'b1 || bus.m_data !== data) stable = 1'b0;
      end
      bus.m_ready = 1'b1;
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.s_ready, bus.m_valid, bus.busy, bus.err, bus.k_r_enable, bus.k_controlArr, bus.k_arr_we} !== 7'b0000010) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000010", {bus.s_ready, bus.m_valid, bus.busy, bus.err,
               bus.k_r_enable, bus.k_controlArr, bus.k_arr_we});
    end
    checks++;
    if (bus.m_data !== 64'sd0 || bus.k_arr_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_data m_data %0d addr %0d exp 0 0", bus.m_data, bus.k_arr_addr);
    end
    checks++;
    if (bus.k_init_i !== 10'd0 || bus.k_init_acc !== 64'd0) begin
      errors++;
      $display("FAIL init_consts got %0d %0d exp 0 0", bus.k_init_i, bus.k_init_acc);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready got %b exp 1", bus.s_ready);
    end
  endtask

  task automatic test_basic();
    bit sent, got, stable;
    logic signed [63:0] d;
    logic e;
    int mvc;
    int a0 = acc_cnt, b0 = beat_cnt, r0 = ren_cnt, o0 = own_bad;
    for (int i = 0; i < N; i++) smp[i] = 27'sd3;
    khang = 1'b0; kcorrupt = 1'b0; klat = 20;
    run_job(0, 0, 1'b1, 1'b1, sent, got, d, e, stable, mvc);
    checks++;
    if (!sent || !got) begin errors++; $display("FAIL basic_progress sent %b got %b exp 1 1", sent, got); end
    checks++;
    if (d !== 64'sd9000) begin errors++; $display("FAIL basic_data got %0d exp 9000", d); end
    checks++;
    if (d !== exp_sum()) begin errors++; $display("FAIL basic_model got %0d exp %0d", d, exp_sum()); end
    checks++;
    if (e !== 1'b0 || err_at_start !== 1'b0) begin errors++; $display("FAIL basic_err got %b/%b exp 0", e, err_at_start); end
    checks++;
    if (acc_cnt - a0 != N) begin errors++; $display("FAIL basic_accepted got %0d exp %0d", acc_cnt - a0, N); end
    checks++;
    if (beat_cnt - b0 != 1) begin errors++; $display("FAIL basic_beats got %0d exp 1", beat_cnt - b0); end
    checks++;
    if (ren_cnt - r0 != 1 || own_bad != o0) begin
      errors++; $display("FAIL basic_start pulses %0d owned %0d exp 1 0", ren_cnt - r0, own_bad - o0);
    end
    checks++;
    if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0 || bus.k_controlArr !== 1'b1) begin
      errors++; $display("FAIL basic_done mv %b busy %b ctrl %b exp 0 0 1", bus.m_valid, bus.busy, bus.k_controlArr);
    end
  endtask

  task automatic test_mixed();
    bit sent, got, stable;
    logic signed [63:0] d;
    logic e;
    int mvc;
    logic signed [DW-1:0] lo, hi;
    longint want;
    lo = 27'h4000000;
    hi = 27'h3FFFFFF;
    want = 64'sd500 * (64'sd1 <<< 52) + 64'sd500 * 64'sd67108863 * 64'sd67108863;
    for (int i = 0; i < N; i++) smp[i] = (i % 2 == 0) ? lo : hi;
    klat = 0;
    run_job(0, 0, 1'b1, 1'b0, sent, got, d, e, stable, mvc);
    checks++;
    if (!sent || !got || d !== want) begin
      errors++; $display("FAIL mixed_data got %0d exp %0d", d, want);
    end
    checks++;
    if (d !== exp_sum()) begin errors++; $display("FAIL mixed_model got %0d exp %0d", d, exp_sum()); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL mixed_err got %b exp 0", e); end
  endtask

  task automatic test_backpressure();
    bit sent, got, stable;
    logic signed [63:0] d;
    logic e;
    int mvc;
    int b0 = beat_cnt, s0 = sready_bad;
    for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
    klat = int'($urandom_range(5, 60));
    run_job(40, 50, 1'b0, 1'b0, sent, got, d, e, stable, mvc);
    checks++;
    if (!sent || !got || d !== exp_sum()) begin
      errors++; $display("FAIL bp_data got %0d exp %0d", d, exp_sum());
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_hold result changed while m_ready low, exp stable"); end
    checks++;
    if (beat_cnt - b0 != 1) begin errors++; $display("FAIL bp_beats got %0d exp 1", beat_cnt - b0); end
    checks++;
    if (sready_bad != s0) begin errors++; $display("FAIL bp_sready got %0d cycles exp 0", sready_bad - s0); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL bp_err got %b exp 0", e); end
  endtask

  task automatic test_verify_fault();
    bit sent, got, stable;
    logic signed [63:0] d;
    logic e;
    int mvc;
    int r0 = ren_cnt;
    for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
    kcorrupt = 1'b1;
    klat = 15;
    run_job(10, 3, 1'b0, 1'b0, sent, got, d, e, stable, mvc);
    kcorrupt = 1'b0;
    checks++;
    if (err_at_start !== 1'b1) begin errors++; $display("FAIL vf_err_at_start got %b exp 1", err_at_start); end
    checks++;
    if (ren_cnt - r0 != 1 || !got) begin
      errors++; $display("FAIL vf_kernel_ran pulses %0d got %b exp 1 1", ren_cnt - r0, got);
    end
    checks++;
    if (d !== exp_sum() || e !== 1'b1) begin
      errors++; $display("FAIL vf_result got %0d err %b exp %0d err 1", d, e, exp_sum());
    end
  endtask

  task automatic test_timeout();
    bit sent, got, stable;
    logic signed [63:0] d;
    logic e;
    int mvc, lat;
    for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
    khang = 1'b1;
    run_job(5, 2, 1'b0, 1'b0, sent, got, d, e, stable, mvc);
    khang = 1'b0;
    lat = mvc - ren_cyc;
    checks++;
    if (!got || d !== 64'sd0 || e !== 1'b1) begin
      errors++; $display("FAIL to_result got %b data %0d err %b exp 1 0 1", got, d, e);
    end
    checks++;
    if (lat < 95 || lat > 110) begin errors++; $display("FAIL to_latency got %0d exp about 100", lat); end
  endtask

  task automatic test_reset_midload();
    bit ok, sent, got, stable;
    logic signed [63:0] d;
    logic e;
    int mvc, a0;
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bus.err); end
    for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
    a0 = acc_cnt;
    drive_samples(0, 1, 0, ok);
    @(negedge clk);
    bus.s_valid = 1'b0;
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL first_sample err %b busy %b exp 0 1", bus.err, bus.busy);
    end
    drive_samples(1, 500, 20, ok);
    @(negedge clk);
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || acc_cnt - a0 != 500) begin errors++; $display("FAIL ml_accepted got %0d exp 500", acc_cnt - a0); end
    checks++;
    if ({bus.s_ready, bus.m_valid, bus.busy, bus.err, bus.k_r_enable, bus.k_controlArr, bus.k_arr_we} !== 7'b0000010 ||
        bus.m_data !== 64'sd0 || bus.k_arr_addr !== 10'd0) begin
      errors++;
      $display("FAIL ml_reset flags %b addr %0d data %0d exp 0000010 0 0", {bus.s_ready, bus.m_valid, bus.busy,
               bus.err, bus.k_r_enable, bus.k_controlArr, bus.k_arr_we}, bus.k_arr_addr, bus.m_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
    klat = 30;
    run_job(15, 4, 1'b0, 1'b0, sent, got, d, e, stable, mvc);
    checks++;
    if (!sent || !got || d !== exp_sum() || e !== 1'b0) begin
      errors++; $display("FAIL ml_rejob got %0d err %b exp %0d err 0", d, e, exp_sum());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_backpressure();
    test_verify_fault();
    test_timeout();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
